controle: RTL and testbench
===========================

Name: controle

Overview:
- Multicycle MIPS main control unit: Moore FSM main decoder plus combinational ALU decoder.
- Sits beside the multicycle datapath; sequences fetch/decode/execute/memory/writeback for lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, j.
- Drives all datapath enables and muxes. PC enable is formed outside as PCWrite | (Branch & Zero) | (BranchNE & ~Zero).

Parameters:
- none. Opcodes, functs and state encodings are constants in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- MemtoReg  out  1  register write data: 1=memory data, 0=ALUOut
- RegDst  out  1  destination register: 1=rd, 0=rt
- IorD  out  1  memory address: 1=ALUOut, 0=PC
- ALUSrcA  out  1  ALU A input: 1=register A, 0=PC
- IRWrite  out  1  instruction register load
- MemWrite  out  1  memory write
- PCWrite  out  1  unconditional PC write
- Branch  out  1  beq branch enable
- RegWrite  out  1  register file write
- BranchNE  out  1  bne branch enable
- PCSrc  out  2  next PC: 00=ALUResult, 01=ALUOut, 10=jump target
- ALUSrcB  out  2  ALU B input: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- ALUControl  out  3  ALU operation

Behaviour:
- Moore FSM. Outputs are a function of state only; ALUControl also depends on funct. State register updates on rising clk. rst=0 asynchronously forces FETCH.
- Outputs during reset are the FETCH outputs. Every output not listed as asserted in a state is 0 (no X).
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, j=000010.
- States, asserted outputs (ALUOp internal) and next state:
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by opcode: lw/sw→MEMADR, R→RTYPEEX, beq→BEQEX, bne→BNEEX, addi→ADDIEX, j→JEX, any other opcode→FETCH.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw→MEMRD, sw→MEMWR, otherwise FETCH.
  - MEMRD: IorD=1. Next: MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR: IorD=1, MemWrite=1. Next: FETCH.
  - RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RTYPEWB.
  - RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
  - BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
  - BNEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, BranchNE=1. Next: FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
  - JEX: PCSrc=10, PCWrite=1. Next: FETCH.
  - Illegal state encoding→FETCH.
- Latency in cycles, including FETCH: lw 5; sw, R, addi 4; beq, bne, j 3.
- ALU decoder (combinational):
  - ALUOp 00→010 (add).
  - ALUOp 01→110 (sub).
  - ALUOp 11→010.
  - ALUOp 10, by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other funct→000.
- opcode and funct are sampled only at state-transition edges and are never latched. Reset mid-instruction aborts to FETCH immediately, without waiting for a clock edge.

Decomposition:
- Package controle_pkg: opcode and funct localparams, state enum (13 states), ALUOp typedef (2 bits), ALUControl codes.
- One sub-module, aludec (ALUOp, funct → ALUControl). The FSM main decoder stays in controle.

Test Plan:
- rst=0 while clk toggles → FETCH outputs held: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010, all others 0. Release rst → DECODE: ALUSrcB=11, ALUControl=010.
- lw (100011) sequence → MEMADR (ALUSrcA=1, ALUSrcB=10), MEMRD (IorD=1), MEMWB (MemtoReg=1, RegWrite=1), then FETCH. sw (101011) → MEMADR, then MEMWR (IorD=1, MemWrite=1).
- R-type with funct 100000/100010/100100/100101/101010 → RTYPEEX ALUControl = 010/110/000/001/111 respectively, then RTYPEWB with RegDst=1, RegWrite=1.
- beq (000100) → BEQEX: Branch=1, PCSrc=01, ALUControl=110, BranchNE=0. bne (000101) → BNEEX: BranchNE=1, Branch=0.
- addi (001000) → ADDIEX (ALUSrcB=10, ALUControl=010), then ADDIWB (RegWrite=1, RegDst=0). j (000010) → JEX: PCSrc=10, PCWrite=1.
- Undefined opcode 111111 at DECODE → next cycle FETCH. Assert rst=0 mid-RTYPEEX → FETCH outputs appear immediately, before the next clk edge.

Source files
------------

// File: rtl/controle_pkg.sv
// controle_pkg: opcodes, functs, FSM states and ALU codes shared by the MIPS multicycle control
package controle_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
    RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX
  } state_t;
  typedef logic [1:0] aluop_t;
  localparam aluop_t ALUOP_ADD   = 2'b00;
  localparam aluop_t ALUOP_SUB   = 2'b01;
  localparam aluop_t ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/controle_aludec.sv
// aludec: maps ALUOp and funct to the ALU operation code
module aludec
  import controle_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);
  logic [2:0] fn_op;
  always_comb begin
    fn_op = (funct == FN_ADD) ? ALU_ADD :
            (funct == FN_SUB) ? ALU_SUB :
            (funct == FN_AND) ? ALU_AND :
            (funct == FN_OR)  ? ALU_OR  :
            (funct == FN_SLT) ? ALU_SLT : ALU_AND;
    alu_control = (aluop == ALUOP_SUB)   ? ALU_SUB :
                  (aluop == ALUOP_FUNCT) ? fn_op   : ALU_ADD;
  end
endmodule

// File: rtl/controle.sv
// controle: multicycle MIPS main control, Moore FSM decoder plus ALU decoder
module controle
  import controle_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic       BranchNE,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl
);
  state_t state, next;
  aluop_t aluop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:   next = DECODE;
      DECODE:  next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      (opcode == OP_R)    ? RTYPEEX :
                      (opcode == OP_BEQ)  ? BEQEX   :
                      (opcode == OP_BNE)  ? BNEEX   :
                      (opcode == OP_ADDI) ? ADDIEX  :
                      (opcode == OP_J)    ? JEX     : FETCH;
      MEMADR:  next = (opcode == OP_LW) ? MEMRD : (opcode == OP_SW) ? MEMWR : FETCH;
      MEMRD:   next = MEMWB;
      RTYPEEX: next = RTYPEWB;
      ADDIEX:  next = ADDIWB;
      default: next = FETCH;
    endcase
  end
  always_comb begin
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    BranchNE = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    aluop    = ALUOP_ADD;
    case (state)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      DECODE:  ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD:   IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      RTYPEEX: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BEQEX: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      BNEEX: begin
        ALUSrcA  = 1'b1;
        aluop    = ALUOP_SUB;
        PCSrc    = 2'b01;
        BranchNE = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:  RegWrite = 1'b1;
      JEX: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end
  aludec u_aludec (.aluop(aluop), .funct(funct), .alu_control(ALUControl));
endmodule

// File: tb/tb_controle.sv
// tb_controle: scoreboard bench walking every instruction class through the control FSM
module tb_controle;
  logic       clk_tb = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic [5:0] funct = 6'b0;
  logic       MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite;
  logic       Branch, RegWrite, BranchNE;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  int n_checks = 0;
  int n_errors = 0;
  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;
  exp_t sb[$];
  // {MemtoReg,RegDst,IorD,ALUSrcA,IRWrite,MemWrite,PCWrite,Branch,RegWrite,BranchNE,PCSrc,ALUSrcB,ALUControl}
  localparam logic [16:0] E_FETCH   = 17'b0000101000_00_01_010;
  localparam logic [16:0] E_DECODE  = 17'b0000000000_00_11_010;
  localparam logic [16:0] E_MEMADR  = 17'b0001000000_00_10_010;
  localparam logic [16:0] E_MEMRD   = 17'b0010000000_00_00_010;
  localparam logic [16:0] E_MEMWB   = 17'b1000000010_00_00_010;
  localparam logic [16:0] E_MEMWR   = 17'b0010010000_00_00_010;
  localparam logic [16:0] E_RTYPEEX = 17'b0001000000_00_00_000;
  localparam logic [16:0] E_RTYPEWB = 17'b0100000010_00_00_010;
  localparam logic [16:0] E_BEQEX   = 17'b0001000100_01_00_110;
  localparam logic [16:0] E_BNEEX   = 17'b0001000001_01_00_110;
  localparam logic [16:0] E_ADDIEX  = 17'b0001000000_00_10_010;
  localparam logic [16:0] E_ADDIWB  = 17'b0000000010_00_00_010;
  localparam logic [16:0] E_JEX     = 17'b0000001000_10_00_010;
  wire [16:0] outs = {MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
                      Branch, RegWrite, BranchNE, PCSrc, ALUSrcB, ALUControl};

  controle dut (
    .clk(clk_tb), .rst(rst), .opcode(opcode), .funct(funct),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch),
    .RegWrite(RegWrite), .BranchNE(BranchNE), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl)
  );

  always #5 clk_tb = ~clk_tb;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [16:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(posedge clk_tb);
      #1;
      e = sb.pop_front();
      check(e.tag, outs, e.v);
    end
  endtask

  task automatic instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [2:0] rt_alu);
    opcode = op;
    funct  = fn;
    push({name, "_decode"}, E_DECODE);
    case (op)
      6'b100011: begin
        push({name, "_memadr"}, E_MEMADR);
        push({name, "_memrd"}, E_MEMRD);
        push({name, "_memwb"}, E_MEMWB);
      end
      6'b101011: begin
        push({name, "_memadr"}, E_MEMADR);
        push({name, "_memwr"}, E_MEMWR);
      end
      6'b000000: begin
        push({name, "_rtypeex"}, E_RTYPEEX | {14'b0, rt_alu});
        push({name, "_rtypewb"}, E_RTYPEWB);
      end
      6'b000100: push({name, "_beqex"}, E_BEQEX);
      6'b000101: push({name, "_bneex"}, E_BNEEX);
      6'b001000: begin
        push({name, "_addiex"}, E_ADDIEX);
        push({name, "_addiwb"}, E_ADDIWB);
      end
      6'b000010: push({name, "_jex"}, E_JEX);
      default: ;
    endcase
    push({name, "_fetch"}, E_FETCH);
    drain();
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk_tb);
      check("reset_hold", outs, E_FETCH);
    end
    rst = 1'b1;
    instr("lw", 6'b100011, 6'b000000, 3'b000);
    instr("sw", 6'b101011, 6'b000000, 3'b000);
    instr("add", 6'b000000, 6'b100000, 3'b010);
    instr("sub", 6'b000000, 6'b100010, 3'b110);
    instr("and", 6'b000000, 6'b100100, 3'b000);
    instr("or", 6'b000000, 6'b100101, 3'b001);
    instr("slt", 6'b000000, 6'b101010, 3'b111);
    instr("rbad", 6'b000000, 6'b111111, 3'b000);
    instr("beq", 6'b000100, 6'b000000, 3'b000);
    instr("bne", 6'b000101, 6'b000000, 3'b000);
    instr("addi", 6'b001000, 6'b000000, 3'b000);
    instr("j", 6'b000010, 6'b000000, 3'b000);
    instr("undef", 6'b111111, 6'b000000, 3'b000);
    opcode = 6'b000000;
    funct  = 6'b100010;
    push("mid_decode", E_DECODE);
    push("mid_rtypeex", E_RTYPEEX | 17'd6);
    drain();
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", outs, E_FETCH);
    @(negedge clk_tb);
    check("async_reset_hold", outs, E_FETCH);
    rst = 1'b1;
    instr("post_reset_add", 6'b000000, 6'b100000, 3'b010);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
